// File: rtl/pointer_fetch_ctrl.sv
// Pointer sprite scanline sequencer: fetches the next line's 8-word pointer row from
// pointermem during hblank and streams the previous line's row as registered pixels.
module pointer_fetch_ctrl #(
  parameter int AWIDTH = 8,
  parameter int CW     = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pointer_en_i,
  input  logic [CW-1:0]     pointer_x_i,
  input  logic [CW-1:0]     pointer_y_i,
  input  logic              line_start_i,
  input  logic [CW-1:0]     next_line_i,
  input  logic              h_active_i,
  input  logic [CW-1:0]     h_count_i,
  output logic [AWIDTH-1:0] rd_address_o,
  input  logic [15:0]       rd_data_i,
  output logic [3:0]        pixel_o,
  output logic              pixel_valid_o,
  output logic              fetch_busy_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [4:0]        row_q, row_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              disp_valid_q, disp_valid_d;
  logic              busy_q, busy_d;
  logic [3:0]        pixel_q, pixel_d;
  logic              pix_valid_q, pix_valid_d;
  logic [15:0]       fetch_buf_q [8];
  logic [15:0]       fetch_buf_d [8];
  logic [15:0]       disp_buf_q [8];
  logic [15:0]       disp_buf_d [8];

  logic [CW-1:0]     row_s;
  logic              hit_s;
  logic [CW-1:0]     col_s;
  logic              in_win_s;
  logic [15:0]       word_s;
  logic [3:0]        nib_s;

  // Row select, buffer swap and fetch sequencing
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    row_d         = row_q;
    addr_d        = addr_q;
    fetch_valid_d = fetch_valid_q;
    disp_valid_d  = disp_valid_q;
    fetch_buf_d   = fetch_buf_q;
    disp_buf_d    = disp_buf_q;
    // Lines above the pointer wrap to a large unsigned row and miss
    row_s = next_line_i - pointer_y_i;
    hit_s = pointer_en_i && (row_s < CW'(32));
    if (line_start_i) begin
      disp_buf_d    = fetch_buf_q;
      disp_valid_d  = (state_q == DONE) && fetch_valid_q;
      fetch_valid_d = 1'b0;
      if (hit_s) begin
        state_d = FETCH;
        idx_d   = 3'd0;
        row_d   = row_s[4:0];
        addr_d  = AWIDTH'({row_s[4:0], 3'b000});
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        FETCH: begin
          // Data for word idx-1 arrives one cycle after its address
          if (idx_q != 3'd0) begin
            fetch_buf_d[idx_q - 3'd1] = rd_data_i;
          end else begin
            fetch_buf_d = fetch_buf_q;
          end
          if (idx_q == 3'd7) begin
            state_d = DRAIN;
          end else begin
            idx_d  = idx_q + 3'd1;
            addr_d = AWIDTH'({row_q, idx_q + 3'd1});
          end
        end
        DRAIN: begin
          fetch_buf_d[7] = rd_data_i;
          fetch_valid_d  = 1'b1;
          state_d        = DONE;
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  // Display window and nibble selection, one cycle ahead of the outputs
  always_comb begin
    col_s    = h_count_i - pointer_x_i;
    in_win_s = h_active_i && disp_valid_q && (col_s < CW'(32));
    word_s   = disp_buf_q[col_s[4:2]];
    case (col_s[1:0])
      2'd0:    nib_s = word_s[15:12];
      2'd1:    nib_s = word_s[11:8];
      2'd2:    nib_s = word_s[7:4];
      2'd3:    nib_s = word_s[3:0];
      default: nib_s = 4'd0;
    endcase
    if (in_win_s) begin
      pixel_d     = nib_s;
      pix_valid_d = 1'b1;
    end else begin
      pixel_d     = 4'd0;
      pix_valid_d = 1'b0;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= 3'd0;
      row_q         <= 5'd0;
      addr_q        <= '0;
      fetch_valid_q <= 1'b0;
      disp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      pixel_q       <= 4'd0;
      pix_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      row_q         <= row_d;
      addr_q        <= addr_d;
      fetch_valid_q <= fetch_valid_d;
      disp_valid_q  <= disp_valid_d;
      busy_q        <= busy_d;
      pixel_q       <= pixel_d;
      pix_valid_q   <= pix_valid_d;
    end
  end

  // Row buffers hold no reset value; their valid flags gate every use
  always_ff @(posedge clk) begin
    fetch_buf_q <= fetch_buf_d;
    disp_buf_q  <= disp_buf_d;
  end

  assign rd_address_o  = addr_q;
  assign pixel_o       = pixel_q;
  assign pixel_valid_o = pix_valid_q;
  assign fetch_busy_o  = busy_q;

endmodule

// File: tb/tb_pointer_fetch_ctrl.sv
// Self-checking bench for pointer_fetch_ctrl: directed steps then randomized lines,
// compared against a line-level reference model of the pointer fetch/display rules.
module tb_pointer_fetch_ctrl;
  localparam int CW = 11;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pointer_en_i;
  logic [CW-1:0] pointer_x_i, pointer_y_i, next_line_i, h_count_i;
  logic          line_start_i, h_active_i;
  logic [AW-1:0] rd_address_o;
  logic [15:0]   rd_data_i;
  logic [3:0]    pixel_o;
  logic          pixel_valid_o, fetch_busy_o;

  pointer_fetch_ctrl #(.AWIDTH(AW), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .pointer_en_i(pointer_en_i),
    .pointer_x_i(pointer_x_i), .pointer_y_i(pointer_y_i),
    .line_start_i(line_start_i), .next_line_i(next_line_i),
    .h_active_i(h_active_i), .h_count_i(h_count_i),
    .rd_address_o(rd_address_o), .rd_data_i(rd_data_i),
    .pixel_o(pixel_o), .pixel_valid_o(pixel_valid_o), .fetch_busy_o(fetch_busy_o)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) rd_data_i <= mem[rd_address_o];

  int tests = 0;
  int fails = 0;
  int vcount;

  // Reference model: row being fetched, edges since its line start, displayed row
  bit m_act;
  int m_row;
  int m_cnt;
  bit m_dv;
  int m_drow;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_pix(input int h, input bit ha);
    int col;
    logic [15:0] w;
    col = (h - int'(pointer_x_i)) & 2047;
    if (ha && m_dv && col < 32) begin
      w = mem[m_drow * 8 + col / 4];
      return {1'b1, 4'(w >> (12 - 4 * (col % 4)))};
    end
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_act = 1'b0;
    m_dv  = 1'b0;
    m_cnt = 1000;
  endtask

  task automatic cyc(input bit ls, input int nl, input bit ha, input int hc);
    logic [4:0] e;
    int row;
    @(negedge clk);
    line_start_i = ls;
    next_line_i  = CW'(nl);
    h_active_i   = ha;
    h_count_i    = CW'(hc);
    e = exp_pix(hc & 2047, ha);
    @(posedge clk);
    if (ls) begin
      m_dv   = m_act && (m_cnt >= 9);
      m_drow = m_row;
      row    = (nl - int'(pointer_y_i)) & 2047;
      m_act  = pointer_en_i && (row < 32);
      if (m_act) m_row = row;
      m_cnt  = 0;
    end else if (m_cnt < 1000) begin
      m_cnt++;
    end
    #1;
    check("pix_valid", 16'(pixel_valid_o), 16'(e[4]));
    check("pixel", 16'(pixel_o), 16'(e[3:0]));
    check("busy", 16'(fetch_busy_o), 16'(m_act && m_cnt <= 8));
    if (m_act && m_cnt <= 8)
      check("rd_addr", 16'(rd_address_o), 16'(m_row * 8 + (m_cnt > 7 ? 7 : m_cnt)));
    if (pixel_valid_o === 1'b1) vcount++;
  endtask

  task automatic sweep(input int lo, input int hi);
    vcount = 0;
    for (int h = lo; h <= hi; h++) cyc(1'b0, 0, 1'b1, h);
    cyc(1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    for (int n = 0; n < 256; n++) mem[n] = {n[7:0], n[7:0]};
    reset_n = 1'b0;
    pointer_en_i = 1'b1; pointer_x_i = CW'(50); pointer_y_i = CW'(100);
    line_start_i = 1'b0; next_line_i = '0; h_active_i = 1'b0; h_count_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 16'(rd_address_o), 16'd0);
    check("rst_pixel", 16'(pixel_o), 16'd0);
    check("rst_valid", 16'(pixel_valid_o), 16'd0);
    check("rst_busy", 16'(fetch_busy_o), 16'd0);
    @(negedge clk); reset_n = 1'b1;

    // Fetch row 3 (addresses 24..31), busy for 9 cycles
    cyc(1'b1, 103, 1'b0, 0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 0, 1'b0, 0);

    // Display row 3 at x=50
    cyc(1'b1, 104, 1'b0, 0);
    vcount = 0;
    for (int h = 0; h <= 100; h++) begin
      cyc(1'b0, 0, 1'b1, h);
      if (h == 54) check("h54_pixel", 16'(pixel_o), 16'h1);
      if (h == 55) check("h55_pixel", 16'(pixel_o), 16'h9);
    end
    check("x50_count", 16'(vcount), 16'd32);

    // Misses above and below the sprite
    cyc(1'b1, 99, 1'b0, 0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b1, 132, 1'b0, 0);
    sweep(0, 100);
    check("miss_count", 16'(vcount), 16'd0);

    // Aborted fetch shows nothing; the restarted one completes
    cyc(1'b1, 110, 1'b0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b1, 111, 1'b0, 0);
    sweep(0, 100);
    check("abort_count", 16'(vcount), 16'd0);
    cyc(1'b1, 112, 1'b0, 0);
    sweep(0, 100);
    check("restart_count", 16'(vcount), 16'd32);

    // Pointer wrapping off the left edge
    pointer_x_i = CW'(2040);
    cyc(1'b1, 105, 1'b0, 0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b1, 106, 1'b0, 0);
    sweep(0, 40);
    check("wrap_count", 16'(vcount), 16'd24);

    // Reset in the middle of a fetch
    pointer_x_i = CW'(50);
    cyc(1'b1, 107, 1'b0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 0);
    #1 reset_n = 1'b0;
    #1;
    check("arst_addr", 16'(rd_address_o), 16'd0);
    check("arst_pixel", 16'(pixel_o), 16'd0);
    check("arst_valid", 16'(pixel_valid_o), 16'd0);
    check("arst_busy", 16'(fetch_busy_o), 16'd0);
    model_reset();
    for (int n = 0; n < 256; n++) mem[n] = 16'($urandom);
    @(negedge clk); reset_n = 1'b1;
    cyc(1'b1, 108, 1'b0, 0);
    sweep(0, 100);
    check("post_rst_count", 16'(vcount), 16'd0);

    // Randomized lines
    for (int l = 0; l < 40; l++) begin
      int x, y, gap;
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(2016, 2047) : $urandom_range(0, 600);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(2016, 2047) : $urandom_range(0, 600);
      pointer_x_i  = CW'(x);
      pointer_y_i  = CW'(y);
      pointer_en_i = ($urandom_range(0, 4) != 0);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 12) : $urandom_range(20, 60);
      cyc(1'b1, (y + $urandom_range(0, 40) - 4) & 2047, 1'b0, 0);
      for (int i = 0; i < gap; i++) begin
        if ($urandom_range(0, 5) == 0) pointer_en_i = ~pointer_en_i;
        cyc(1'b0, 0, ($urandom_range(0, 7) != 0), (x - 4 + i) & 2047);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
